xor_selftest_ctrl: RTL and testbench

- Built-in self-test sequencer for the XOR gate datapath.
- On start it sweeps every operand combination into the gate under test and waits a programmable settle time.
- It then samples the gate output, compares it against the expected A^B, and counts mismatches.
- Reports done/pass, error count and the first failing vector. Sits beside the gate as its driver; replaces bench-only truth-table sweeps with a synthesizable checker.

---
 rtl/xor_selftest_ctrl_pkg.sv | 20 ++
 rtl/xor_selftest_ctrl_if.sv | 32 +++
 rtl/xor_selftest_errcnt.sv | 23 ++
 rtl/xor_selftest_ctrl.sv | 121 ++++++++++++
 tb/tb_xor_selftest_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_selftest_ctrl_pkg.sv
// Shared types for the XOR gate self-test controller: FSM states and sweep sizing.
// The vector count is derived from the operand width so every gate width shares one definition.
package xor_selftest_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Settle counter width; SETTLE is legal up to 255.
  localparam int SETTLE_W = 8;

  // Number of operand pairs swept for a given operand width: 2^(2*width).
  function automatic longint unsigned vec_count(input int width);
    return 64'd1 << (2 * width);
  endfunction

endpackage

// File: rtl/xor_selftest_ctrl_if.sv
// Self-test bus: start request, operands to the gate, gate output back, and the result/status set.
// master is the controller side; slave is the environment that starts sweeps and hosts the gate.
interface xor_selftest_ctrl_if
  import xor_selftest_ctrl_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int ERR_W = 16
) ();

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;

  modport master (
    input  start, dut_y,
    output op_a, op_b, busy, done, pass, err_count, fail_valid, fail_a, fail_b
  );

  modport slave (
    output start, dut_y,
    input  op_a, op_b, busy, done, pass, err_count, fail_valid, fail_a, fail_b
  );

endinterface

// File: rtl/xor_selftest_errcnt.sv
// Saturating error counter with synchronous clear; increments are accepted on the cycle they are raised.
// Once all ones the count holds until clear or reset, so extra errors never wrap.
module xor_selftest_errcnt
  import xor_selftest_ctrl_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [ERR_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ERR_W'(1);
    end
  end

endmodule

// File: rtl/xor_selftest_ctrl.sv
// BIST sequencer for a WIDTH-bit XOR gate: sweeps all operand pairs, waits SETTLE cycles per vector, checks Y.
// One vector every SETTLE+1 cycles; start is ignored while busy, results hold in DONE until start or rst.
module xor_selftest_ctrl
  import xor_selftest_ctrl_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  xor_selftest_ctrl_if.master bus
);

  localparam int VW = 2 * WIDTH;
  localparam logic [VW-1:0]       LAST_VEC   = VW'(vec_count(WIDTH) - 64'd1);
  localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE);

  state_e               state_q;
  state_e               state_d;
  logic [VW-1:0]        vec_q;
  logic [SETTLE_W-1:0]  settle_q;
  logic                 fail_valid_q;
  logic [WIDTH-1:0]     fail_a_q;
  logic [WIDTH-1:0]     fail_b_q;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [ERR_W-1:0]     err_count;
  logic                 sweep_clr;
  logic                 do_check;
  logic                 last_vec;
  logic                 mismatch;

  assign op_a     = vec_q[VW-1:WIDTH];
  assign op_b     = vec_q[WIDTH-1:0];
  assign last_vec = (vec_q == LAST_VEC);
  // Any differing bit makes the whole vector one error.
  assign mismatch = (bus.dut_y != (op_a ^ op_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sweep_clr = 1'b0;
    do_check  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = WAIT;
          sweep_clr = 1'b1;
        end
      end
      WAIT: begin
        if (settle_q <= SETTLE_W'(1)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        do_check = 1'b1;
        state_d  = last_vec ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q        <= '0;
      settle_q     <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
    end else if (sweep_clr) begin
      vec_q        <= '0;
      settle_q     <= SETTLE_LD;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
    end else if (state_q == WAIT) begin
      settle_q <= settle_q - SETTLE_W'(1);
    end else if (do_check) begin
      if (mismatch && !fail_valid_q) begin
        fail_valid_q <= 1'b1;
        fail_a_q     <= op_a;
        fail_b_q     <= op_b;
      end
      // The last vector stays on the operands after the sweep ends.
      if (!last_vec) begin
        vec_q    <= vec_q + VW'(1);
        settle_q <= SETTLE_LD;
      end
    end
  end

  xor_selftest_errcnt #(
    .ERR_W (ERR_W)
  ) u_errcnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (sweep_clr),
    .inc   (do_check && mismatch),
    .count (err_count)
  );

  assign bus.op_a       = op_a;
  assign bus.op_b       = op_b;
  assign bus.busy       = (state_q == WAIT) || (state_q == CHECK);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = (state_q == DONE) && (err_count == '0);
  assign bus.err_count  = err_count;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_a     = fail_a_q;
  assign bus.fail_b     = fail_b_q;

endmodule

// File: tb/tb_xor_selftest_ctrl.sv
// Bench for xor_selftest_ctrl: two instances (1-bit/settle 1, 2-bit/settle 3/2-bit counter) driving
// a gate model with a per-vector fault table, checked every cycle against a timeline-based reference.
module tb_xor_selftest_ctrl;
  import xor_selftest_ctrl_pkg::*;

  localparam int SA = 1;
  localparam int NA = 4;
  localparam int EMAX_A = 65535;
  localparam int SB = 3;
  localparam int NB = 16;
  localparam int EMAX_B = 3;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  xor_selftest_ctrl_if #(.WIDTH(1), .ERR_W(16)) bus_a ();
  xor_selftest_ctrl_if #(.WIDTH(2), .ERR_W(2))  bus_b ();

  xor_selftest_ctrl #(.WIDTH(1), .SETTLE(SA), .ERR_W(16)) u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  xor_selftest_ctrl #(.WIDTH(2), .SETTLE(SB), .ERR_W(2)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // Gate under test: correct XOR with a per-vector XOR fault mask.
  bit       mask_a [4];
  bit [1:0] mask_b [16];
  assign bus_a.dut_y = bus_a.op_a ^ bus_a.op_b ^ mask_a[{bus_a.op_a, bus_a.op_b}];
  assign bus_b.dut_y = bus_b.op_a ^ bus_b.op_b ^ mask_b[{bus_b.op_a, bus_b.op_b}];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] op;
    logic        busy;
    logic        done;
    logic [31:0] err;
    logic        fv;
    logic [31:0] fvec;
  } exp_t;

  // Expected outputs d cycles into a sweep (d=1 is the cycle after start was sampled).
  function automatic exp_t model_eval(input bit active, input int d, input int s, input int n,
                                      input int emax, input bit flt [16]);
    exp_t r;
    int   m;
    int   errs;
    r = '0;
    if (active) begin
      if (d <= n * (s + 1)) begin
        r.busy = 1'b1;
        m      = (d - 1) / (s + 1);
        r.op   = 32'(m);
      end else begin
        r.done = 1'b1;
        m      = n;
        r.op   = 32'(n - 1);
      end
      errs = 0;
      for (int k = 0; k < m; k++) begin
        if (flt[k]) begin
          if (!r.fv) begin
            r.fv   = 1'b1;
            r.fvec = 32'(k);
          end
          errs++;
        end
      end
      r.err = 32'((errs > emax) ? emax : errs);
    end
    return r;
  endfunction

  exp_t xa = '0;
  exp_t xb = '0;

  // Compare then advance the model to the state after the coming rising edge.
  initial begin
    int  cyc;
    int  s_a;
    int  s_b;
    bit  act_a;
    bit  act_b;
    bit  flt_a [16];
    bit  flt_b [16];
    cyc = 0; s_a = 0; s_b = 0; act_a = 0; act_b = 0;
    foreach (flt_a[k]) flt_a[k] = 1'b0;
    foreach (flt_b[k]) flt_b[k] = 1'b0;
    forever begin
      @(negedge clk);
      chk("a_op_a", bus_a.op_a, (xa.op >> 1) & 1);
      chk("a_op_b", bus_a.op_b, xa.op & 1);
      chk("a_busy", bus_a.busy, xa.busy);
      chk("a_done", bus_a.done, xa.done);
      chk("a_pass", bus_a.pass, xa.done && (xa.err == 0));
      chk("a_err", bus_a.err_count, xa.err);
      chk("a_fail_valid", bus_a.fail_valid, xa.fv);
      chk("a_fail_a", bus_a.fail_a, (xa.fvec >> 1) & 1);
      chk("a_fail_b", bus_a.fail_b, xa.fvec & 1);
      chk("b_op_a", bus_b.op_a, (xb.op >> 2) & 3);
      chk("b_op_b", bus_b.op_b, xb.op & 3);
      chk("b_busy", bus_b.busy, xb.busy);
      chk("b_done", bus_b.done, xb.done);
      chk("b_pass", bus_b.pass, xb.done && (xb.err == 0));
      chk("b_err", bus_b.err_count, xb.err);
      chk("b_fail_valid", bus_b.fail_valid, xb.fv);
      chk("b_fail_a", bus_b.fail_a, (xb.fvec >> 2) & 3);
      chk("b_fail_b", bus_b.fail_b, xb.fvec & 3);

      cyc++;
      if (rst_a) act_a = 1'b0;
      else if (bus_a.start && !xa.busy) begin
        act_a = 1'b1;
        s_a   = cyc;
        for (int k = 0; k < NA; k++) flt_a[k] = mask_a[k];
      end
      if (rst_b) act_b = 1'b0;
      else if (bus_b.start && !xb.busy) begin
        act_b = 1'b1;
        s_b   = cyc;
        for (int k = 0; k < NB; k++) flt_b[k] = (mask_b[k] != 2'd0);
      end
      xa = model_eval(act_a, cyc - s_a + 1, SA, NA, EMAX_A, flt_a);
      xb = model_eval(act_b, cyc - s_b + 1, SB, NB, EMAX_B, flt_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) bus_b.start = v;
    else     bus_a.start = v;
  endtask

  task automatic set_rst(input bit sel, input logic v);
    if (sel) rst_b = v;
    else     rst_a = v;
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? bus_b.done : bus_a.done;
  endfunction

  // Start in the current cycle T; optional start or reset pulse in cycle T+pulse_at.
  // lat returns k such that done is first seen in cycle T+k (or the cycle after the reset).
  task automatic run(input bit sel, input int pulse_at, input bit is_rst, output int lat);
    set_start(sel, 1'b1);
    step();
    set_start(sel, 1'b0);
    lat = 1;
    chk(sel ? "b_done_cleared" : "a_done_cleared", get_done(sel), 1'b0);
    while (!get_done(sel) && lat < 400) begin
      if (lat == pulse_at) begin
        if (is_rst) set_rst(sel, 1'b1);
        else        set_start(sel, 1'b1);
      end
      step();
      set_start(sel, 1'b0);
      set_rst(sel, 1'b0);
      lat++;
      if (is_rst && lat == pulse_at + 1) break;
    end
    if (!is_rst) chk(sel ? "b_done_in_budget" : "a_done_in_budget", get_done(sel), 1'b1);
  endtask

  initial begin
    int lat;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    foreach (mask_a[k]) mask_a[k] = 1'b0;
    foreach (mask_b[k]) mask_b[k] = 2'd0;
    step();
    step();
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();

    // Correct gate.
    run(0, 0, 0, lat);
    chk("a_ok_latency", lat, 9);
    chk("a_ok_pass", bus_a.pass, 1);
    chk("a_ok_err", bus_a.err_count, 0);
    chk("a_ok_fail_valid", bus_a.fail_valid, 0);

    // Output stuck at 0: vectors 01 and 10 fail.
    for (int k = 0; k < 4; k++) mask_a[k] = ((k >> 1) ^ k) & 1;
    run(0, 0, 0, lat);
    chk("a_stuck_err", bus_a.err_count, 2);
    chk("a_stuck_fail_valid", bus_a.fail_valid, 1);
    chk("a_stuck_fail_a", bus_a.fail_a, 0);
    chk("a_stuck_fail_b", bus_a.fail_b, 1);
    chk("a_stuck_pass", bus_a.pass, 0);

    // Inverted output (XNOR).
    for (int k = 0; k < 4; k++) mask_a[k] = 1'b1;
    run(0, 0, 0, lat);
    chk("a_xnor_latency", lat, 9);
    chk("a_xnor_err", bus_a.err_count, 4);
    chk("a_xnor_fail_a", bus_a.fail_a, 0);
    chk("a_xnor_fail_b", bus_a.fail_b, 0);

    // Start while busy is ignored; start from DONE runs a fresh identical sweep.
    for (int k = 0; k < 4; k++) mask_a[k] = ((k >> 1) ^ k) & 1;
    run(0, 4, 0, lat);
    chk("a_midstart_latency", lat, 9);
    chk("a_midstart_err", bus_a.err_count, 2);
    run(0, 0, 0, lat);
    chk("a_restart_latency", lat, 9);
    chk("a_restart_err", bus_a.err_count, 2);
    chk("a_restart_fail_b", bus_a.fail_b, 1);

    // Reset mid-sweep, then a normal sweep.
    for (int k = 0; k < 4; k++) mask_a[k] = 1'b0;
    run(0, 5, 1, lat);
    chk("a_rst_busy", bus_a.busy, 0);
    chk("a_rst_op_a", bus_a.op_a, 0);
    chk("a_rst_op_b", bus_a.op_b, 0);
    chk("a_rst_err", bus_a.err_count, 0);
    run(0, 0, 0, lat);
    chk("a_post_rst_latency", lat, 9);
    chk("a_post_rst_pass", bus_a.pass, 1);

    // 2-bit gate, fully inverted: counter saturates at 3.
    for (int k = 0; k < 16; k++) mask_b[k] = 2'b11;
    run(1, 0, 0, lat);
    chk("b_inv_latency", lat, 65);
    chk("b_inv_err", bus_b.err_count, 3);
    chk("b_inv_fail_a", bus_b.fail_a, 0);
    chk("b_inv_fail_b", bus_b.fail_b, 0);
    chk("b_inv_pass", bus_b.pass, 0);

    // Single fault on vector a=2,b=1 in one bit.
    for (int k = 0; k < 16; k++) mask_b[k] = 2'd0;
    mask_b[9] = 2'b10;
    run(1, 0, 0, lat);
    chk("b_single_err", bus_b.err_count, 1);
    chk("b_single_fail_a", bus_b.fail_a, 2);
    chk("b_single_fail_b", bus_b.fail_b, 1);

    // Randomized fault tables with stray starts and resets.
    for (int it = 0; it < 12; it++) begin
      bit sel;
      int kind;
      int span;
      sel  = it[0];
      kind = $urandom_range(0, 2);
      for (int k = 0; k < 4; k++)  mask_a[k] = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 16; k++)
        mask_b[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      span = sel ? NB * (SB + 1) : NA * (SA + 1);
      run(sel, (kind == 0) ? 0 : $urandom_range(1, span), kind == 2, lat);
      if (kind != 2) chk(sel ? "b_rand_latency" : "a_rand_latency", lat, span + 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
